buck_converter_top: RTL and testbench

Closed-loop digital controller for a synchronous buck converter. It samples a 12-bit ADC reading of the output voltage and runs a discrete PID on the error against a fixed reference. It produces a 10-bit duty cycle, which drives a fixed-frequency PWM gate signal. It sits between the ADC interface block and the gate driver, and exposes monitor outputs for telemetry.

---
 rtl/buck_pkg.sv | 36 +++
 rtl/buck_converter_if.sv | 12 +
 rtl/buck_converter_pwm_generator.sv | 48 ++++
 rtl/buck_converter_top.sv | 103 ++++++++++
 tb/tb_buck_converter_top.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/buck_pkg.sv
// Shared widths and saturation helpers for the buck converter controller.
// Used by the PID datapath and the PWM generator.
package buck_pkg;

    localparam int ADC_W    = 12;
    localparam int DUTY_W   = 10;
    localparam int ACC_W    = 32;
    localparam int SUM_W    = 48;
    localparam int ERR_W    = ADC_W + 1;
    localparam int DER_W    = ADC_W + 2;
    localparam int DUTY_MAX = (1 << DUTY_W) - 1;

    function automatic logic signed [ACC_W-1:0] sat_acc(
        input logic signed [ACC_W-1:0] v,
        input logic signed [ACC_W-1:0] lim
    );
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic signed [SUM_W-1:0] v);
        if (v < 0) begin
            return '0;
        end else if (v > SUM_W'(DUTY_MAX)) begin
            return '1;
        end else begin
            return v[DUTY_W-1:0];
        end
    endfunction

endpackage

// File: rtl/buck_converter_if.sv
// ADC sample stream into the controller.
// adc_valid is a one-cycle strobe qualifying adc_data; there is no ready, every strobe is accepted.
interface buck_converter_if;
    import buck_pkg::*;

    logic [ADC_W-1:0] adc_data;
    logic             adc_valid;

    modport master (output adc_data, output adc_valid);
    modport slave  (input  adc_data, input  adc_valid);

endinterface

// File: rtl/buck_converter_pwm_generator.sv
// Fixed-frequency PWM: free-running counter, compare shadow-loaded at the period start,
// registered gate output.
module pwm_generator
    import buck_pkg::*;
#(
    parameter int PERIOD = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm_out
);

    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int PROD_W = DUTY_W + CNT_W;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic             pwm_q, pwm_d;
    logic [CNT_W-1:0] cmp_load;

    always_comb begin
        cmp_load = CNT_W'((PROD_W'(duty) * PROD_W'(PERIOD)) >> DUTY_W);
        cnt_d    = (cnt_q == CNT_W'(PERIOD - 1)) ? '0 : cnt_q + CNT_W'(1);
        cmp_d    = cmp_q;
        if (cnt_q == '0) begin
            cmp_d = cmp_load;
        end
        // Compare against the value in force for this period, including the one loaded now.
        // Full duty maps to PERIOD-1, so the last count of every period is always low.
        pwm_d = (cnt_q < cmp_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            cmp_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cmp_q <= cmp_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/buck_converter_top.sv
// Closed-loop buck controller: ADC sample -> PID on (V_REF - sample) -> 10-bit duty -> PWM.
// Two-stage pipeline: sample stage updates error/integral/derivative, PID stage updates duty.
module buck_converter_top
    import buck_pkg::*;
#(
    parameter int                CLK_FREQ  = 100_000_000,
    parameter int                PWM_FREQ  = 100_000,
    parameter logic [ADC_W-1:0]  V_REF     = 12'd2048,
    parameter logic [15:0]       KP        = 16'd100,
    parameter logic [15:0]       KI        = 16'd10,
    parameter logic [15:0]       KD        = 16'd5,
    parameter int                OUT_SHIFT = 8,
    parameter int                INT_LIMIT = 2 ** 20
) (
    input  logic              clk,
    input  logic              rst,
    buck_converter_if.slave   adc,
    output logic              pwm_out,
    output logic [ADC_W-1:0]  voltage_monitor,
    output logic [DUTY_W-1:0] duty_cycle_monitor
);

    localparam int PERIOD = CLK_FREQ / PWM_FREQ;

    localparam logic signed [ACC_W-1:0] LIM  = ACC_W'(INT_LIMIT);
    localparam logic signed [SUM_W-1:0] KP_S = SUM_W'(KP);
    localparam logic signed [SUM_W-1:0] KI_S = SUM_W'(KI);
    localparam logic signed [SUM_W-1:0] KD_S = SUM_W'(KD);

    logic [ADC_W-1:0]        voltage_q, voltage_d;
    logic signed [ERR_W-1:0] error_q, error_d;
    logic signed [DER_W-1:0] deriv_q, deriv_d;
    logic signed [ACC_W-1:0] integral_q, integral_d;
    logic                    pid_vld_q, pid_vld_d;
    logic [DUTY_W-1:0]       duty_q, duty_d;

    logic signed [ERR_W-1:0] err_new;
    logic signed [DER_W-1:0] err_new_x, err_old_x;
    logic signed [ACC_W-1:0] err_acc;
    logic signed [SUM_W-1:0] e_s, i_s, d_s, u_sum, u_shift;

    // error_q doubles as prev_error: it always holds the error of the last accepted sample.
    always_comb begin
        voltage_d  = voltage_q;
        error_d    = error_q;
        deriv_d    = deriv_q;
        integral_d = integral_q;
        pid_vld_d  = adc.adc_valid;

        err_new   = $signed({1'b0, V_REF}) - $signed({1'b0, adc.adc_data});
        err_new_x = DER_W'(err_new);
        err_old_x = DER_W'(error_q);
        err_acc   = ACC_W'(err_new);

        if (adc.adc_valid) begin
            voltage_d  = adc.adc_data;
            error_d    = err_new;
            deriv_d    = err_new_x - err_old_x;
            integral_d = sat_acc(integral_q + err_acc, LIM);
        end
    end

    always_comb begin
        e_s     = SUM_W'(error_q);
        i_s     = SUM_W'(integral_q);
        d_s     = SUM_W'(deriv_q);
        u_sum   = KP_S * e_s + KI_S * i_s + KD_S * d_s;
        u_shift = u_sum >>> OUT_SHIFT;
        duty_d  = duty_q;
        if (pid_vld_q) begin
            duty_d = clamp_duty(u_shift);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            voltage_q  <= '0;
            error_q    <= '0;
            deriv_q    <= '0;
            integral_q <= '0;
            pid_vld_q  <= 1'b0;
            duty_q     <= '0;
        end else begin
            voltage_q  <= voltage_d;
            error_q    <= error_d;
            deriv_q    <= deriv_d;
            integral_q <= integral_d;
            pid_vld_q  <= pid_vld_d;
            duty_q     <= duty_d;
        end
    end

    pwm_generator #(.PERIOD(PERIOD)) u_pwm (
        .clk     (clk),
        .rst     (rst),
        .duty    (duty_q),
        .pwm_out (pwm_out)
    );

    assign voltage_monitor    = voltage_q;
    assign duty_cycle_monitor = duty_q;

endmodule

// File: tb/tb_buck_converter_top.sv
// Directed bench for buck_converter_top: reset, PID duty values, ramps, integral saturation,
// PWM high-time per period and shadow-load behaviour.
module tb_buck_converter_top;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_out;
    logic [11:0] vmon;
    logic [9:0]  dmon;

    always #5 clk = ~clk;

    buck_converter_if adc_if();

    buck_converter_top dut (
        .clk                (clk),
        .rst                (rst),
        .adc                (adc_if),
        .pwm_out            (pwm_out),
        .voltage_monitor    (vmon),
        .duty_cycle_monitor (dmon)
    );

    int err_cnt = 0;
    int chk_cnt = 0;
    int edges   = 0;
    int hi_p1   = 0;
    int hi_p2   = 0;

    // Edge j after reset release handles PWM count (j-1) mod 1000.
    always @(posedge clk) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            hi_p1 <= 0;
            hi_p2 <= 0;
        end else begin
            if (pwm_out && edges >= 1 && edges <= 1000)    hi_p1 <= hi_p1 + 1;
            if (pwm_out && edges >= 1001 && edges <= 2000) hi_p2 <= hi_p2 + 1;
        end
    end

    task automatic check(input string tag, input longint act, input longint exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Behavioural PID reference with V_REF=2048, KP=100, KI=10, KD=5, shift 8, limit 2^20.
    longint m_int  = 0;
    longint m_prev = 0;

    function automatic int model_step(input int adc);
        longint e, d, u, s;
        e = 2048 - adc;
        m_int = m_int + e;
        if (m_int > 1048576)  m_int = 1048576;
        if (m_int < -1048576) m_int = -1048576;
        d = e - m_prev;
        m_prev = e;
        u = 100 * e + 10 * m_int + 5 * d;
        s = u >>> 8;
        if (s < 0)    s = 0;
        if (s > 1023) s = 1023;
        return int'(s);
    endfunction

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        m_int  = 0;
        m_prev = 0;
    endtask

    // Strobe one sample; voltage_monitor checked one edge later, duty one edge after that.
    task automatic sample_and_check(input int adc, input string tag, input int exp_duty);
        @(negedge clk);
        adc_if.adc_data  = 12'(adc);
        adc_if.adc_valid = 1'b1;
        @(negedge clk);
        adc_if.adc_valid = 1'b0;
        check({tag, "_vmon"}, vmon, adc);
        @(negedge clk);
        check({tag, "_duty"}, dmon, exp_duty);
    endtask

    task automatic count_highs(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_out) cnt++;
        end
    endtask

    task automatic wait_edges(input int target);
        int guard;
        guard = 0;
        while (edges < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_edges_timeout", edges >= target, 1);
    endtask

    initial begin
        int hi, prev_d, mono, hold_d, exp_d;

        adc_if.adc_data  = '0;
        adc_if.adc_valid = 1'b0;

        // Reset held 10 cycles, then one idle period must stay low.
        repeat (10) @(negedge clk);
        check("rst_pwm", pwm_out, 0);
        check("rst_vmon", vmon, 0);
        check("rst_dmon", dmon, 0);
        rst = 1'b0;
        wait_edges(1000);
        check("idle_period_highs", hi_p1, 0);

        // adc=0 after reset: e=2048, I=2048, d=2048 -> u=235520, duty=920, compare=898.
        // Sample lands mid-period, so the first period must stay low.
        do_reset(2);
        wait_edges(299);
        void'(model_step(0));
        sample_and_check(0, "adc0", 920);
        wait_edges(2000);
        check("shadow_p1_highs", hi_p1, 0);
        check("shadow_p2_highs", hi_p2, 898);

        // adc=934: e=1114, u=115*1114=128110 -> duty=500, compare=488.
        do_reset(2);
        void'(model_step(934));
        sample_and_check(934, "d500", 500);
        wait_edges(1100);
        check("d500_pwm_high", pwm_out, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pwm", pwm_out, 0);
        check("midrst_vmon", vmon, 0);
        check("midrst_dmon", dmon, 0);
        rst = 1'b0;
        m_int  = 0;
        m_prev = 0;

        // First sample 1800: duty 111; PWM high 108 of 1000.
        void'(model_step(1800));
        sample_and_check(1800, "first1800", 111);
        repeat (2000) @(negedge clk);
        count_highs(1000, hi);
        check("pwm_108", hi, 108);
        check("hold_no_valid", dmon, 111);

        // Second sample 1800: I=496, d=0 -> u=29760, duty=116.
        void'(model_step(1800));
        sample_and_check(1800, "second1800", 116);

        // Ramp with repeated 1800: rises monotonically to 1023.
        prev_d = 116;
        mono = 1;
        for (int k = 0; k < 118; k++) begin
            exp_d = model_step(1800);
            sample_and_check(1800, "ramp", exp_d);
            if (int'(dmon) < prev_d) mono = 0;
            prev_d = int'(dmon);
        end
        check("ramp_monotonic", mono, 1);
        check("ramp_saturated", dmon, 1023);

        // Zero error: duty held by the integral alone.
        exp_d = model_step(2048);
        sample_and_check(2048, "steady_first", exp_d);
        hold_d = int'(dmon);
        for (int k = 0; k < 6; k++) begin
            exp_d = model_step(2048);
            sample_and_check(2048, "steady", exp_d);
            check("steady_const", dmon, hold_d);
        end

        // Negative error e=-152: monotonic descent to 0, gate held low.
        prev_d = int'(dmon);
        mono = 1;
        for (int k = 0; k < 300; k++) begin
            exp_d = model_step(2200);
            sample_and_check(2200, "fall", exp_d);
            if (int'(dmon) > prev_d) mono = 0;
            prev_d = int'(dmon);
        end
        check("fall_monotonic", mono, 1);
        check("fall_zero", dmon, 0);
        repeat (1000) @(negedge clk);
        count_highs(1000, hi);
        check("pwm_zero", hi, 0);

        // Integral saturation both ways; recovery timing exposes a missing clamp.
        do_reset(2);
        for (int k = 0; k < 600; k++) begin
            exp_d = model_step(0);
            sample_and_check(0, "sat_pos", exp_d);
        end
        for (int k = 0; k < 1100; k++) begin
            exp_d = model_step(4095);
            sample_and_check(4095, "sat_neg", exp_d);
        end
        for (int k = 0; k < 560; k++) begin
            exp_d = model_step(0);
            sample_and_check(0, "sat_recover", exp_d);
        end
        check("sat_recover_end", dmon, 1023);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
